// File: rtl/seq_add_64bit_if.sv
// Handshake and operand/result bundle for the word-serial wide adder.
// Ports (via modports):
//   master : drives start, a, b, cin; observes busy, done, sum, cout, ovf
//   slave  : the adder side, the mirror image of master
interface seq_add_64bit_if #(
  parameter int unsigned NWORDS = 4
);
  localparam int unsigned W = 16 * NWORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_add_64bit.sv
// Word-serial wide adder: one 16-bit carry-select slice adder reused NWORDS
// times, least-significant slice first, carry chained through a register.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seq_add_64bit_if.slave (start/a/b/cin in, busy/done/sum/cout/ovf out)

// 16-bit carry-select adder: four 4-bit blocks, each precomputing both carry cases.
module csla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  localparam int unsigned BLK   = 4;
  localparam int unsigned NBLK  = 16 / BLK;

  logic [NBLK:0] c;
  assign c[0] = cin;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] r0;
    logic [BLK:0] r1;
    assign r0 = {1'b0, a[BLK*g +: BLK]} + {1'b0, b[BLK*g +: BLK]};
    assign r1 = r0 + (BLK+1)'(1);
    assign sum[BLK*g +: BLK] = c[g] ? r1[BLK-1:0] : r0[BLK-1:0];
    assign c[g+1]            = c[g] ? r1[BLK]     : r0[BLK];
  end

  assign cout = c[NBLK];
endmodule

module seq_add_64bit #(
  parameter int unsigned NWORDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_add_64bit_if.slave bus
);
  localparam int unsigned W  = 16 * NWORDS;
  localparam int unsigned KW = 4;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          carry_q, cout_q, ovf_q;
  logic [KW-1:0] k_q;

  logic [15:0]   a_sl_c, b_sl_c, s_sl_c;
  logic          co_sl_c;
  logic          last_c;

  assign last_c = (k_q == KW'(NWORDS - 1));

  // Select the operand slice addressed by k.
  always_comb begin
    a_sl_c = 16'h0;
    b_sl_c = 16'h0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (k_q == KW'(i)) begin
        a_sl_c = a_q[16*i +: 16];
        b_sl_c = b_q[16*i +: 16];
      end
    end
  end

  csla_16bit u_slice (
    .a    (a_sl_c),
    .b    (b_sl_c),
    .cin  (carry_q),
    .sum  (s_sl_c),
    .cout (co_sl_c)
  );

  // State register plus registered Moore flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; busy/done are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (bus.start) state_d = ADD;
      ADD:     if (last_c)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Operand capture and one slice per cycle while in ADD.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            k_q     <= '0;
          end
        end
        ADD: begin
          for (int unsigned i = 0; i < NWORDS; i++) begin
            if (k_q == KW'(i)) sum_q[16*i +: 16] <= s_sl_c;
          end
          carry_q <= co_sl_c;
          k_q     <= k_q + KW'(1);
          if (last_c) begin
            cout_q <= co_sl_c;
            // Signed overflow: like-signed operands giving a result of the other sign.
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (s_sl_c[15] != a_q[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_add_64bit.sv
// Scoreboard bench for seq_add_64bit with NWORDS=4: directed vectors push
// hand-computed results; a negedge monitor pops and compares on each done.
module tb_seq_add_64bit;
  localparam int unsigned NWORDS = 4;
  localparam int unsigned W      = 16 * NWORDS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_add_64bit_if #(.NWORDS(NWORDS)) bus ();

  seq_add_64bit #(.NWORDS(NWORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (sum %h)", bus.sum);
      end else begin
        mon_e = sb.pop_front();
        check("sum",  bus.sum,      mon_e.sum);
        check("cout", W'(bus.cout), W'(mon_e.cout));
        check("ovf",  W'(bus.ovf),  W'(mon_e.ovf));
        // Edges counted inclusively from the accepting edge to the edge raising done.
        check("done_latency", W'(cyc - mon_e.acc + 1), W'(NWORDS + 1));
      end
    end
  end

  // Called at a negedge; returns at a negedge with busy low.
  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                     input logic [W-1:0] es, input logic ec, input logic eo);
    wait_idle();
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    sb.push_back('{sum: es, cout: ec, ovf: eo, acc: cyc});
    @(negedge clk);
  endtask

  initial begin
    int bc;
    int n;

    // Reset held two cycles with start asserted.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 64'h1234_5678_9ABC_DEF0;
    bus.b     = 64'h1111_2222_3333_4444;
    bus.cin   = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_busy", W'(bus.busy), '0);
      check("rst_done", W'(bus.done), '0);
      check("rst_sum",  bus.sum,      '0);
      check("rst_cout", W'(bus.cout), '0);
      check("rst_ovf",  W'(bus.ovf),  '0);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;

    // Basic add, also measuring how long busy stays high.
    wait_idle();
    bus.a     = 64'd25;
    bus.b     = 64'd32;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    sb.push_back('{sum: 64'd57, cout: 1'b0, ovf: 1'b0, acc: cyc});
    bc = 0;
    repeat (8) begin
      if (bus.busy === 1'b1) bc++;
      @(posedge clk);
      #1;
    end
    check("busy_width", W'(bc), W'(NWORDS + 1));
    @(negedge clk);

    // Cross-slice carries and signed overflow.
    add(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    add(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'h0,                   1'b1, 1'b0);
    add(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    add(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
    add(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 64'd1,                   1'b1, 1'b0);

    // Handshake: start held high, operand changed after acceptance.
    wait_idle();
    bus.a     = 64'd64;
    bus.b     = 64'd64;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{sum: 64'd128, cout: 1'b0, ovf: 1'b0, acc: cyc});
    @(negedge clk);
    bus.a = 64'd1000;
    repeat (5) @(posedge clk);
    #1;
    check("no_accept_before_E6", W'(bus.busy), '0);
    @(posedge clk);
    #1;
    check("accept_at_E6", W'(bus.busy), W'(1));
    sb.push_back('{sum: 64'd1064, cout: 1'b0, ovf: 1'b0, acc: cyc});
    bus.start = 1'b0;
    @(negedge clk);

    // Reset in the middle of an addition.
    wait_idle();
    bus.a     = 64'd123;
    bus.b     = 64'd50;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", W'(bus.busy), '0);
    check("midrst_sum",  bus.sum,      '0);
    check("midrst_done", W'(bus.done), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    add(64'd123, 64'd50, 1'b0, 64'd173, 1'b0, 1'b0);

    // Drain remaining expectations with a bounded wait.
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("scoreboard_drain", W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
